uart_word_loader: RTL

UART_WORD_LOADER -- requirements
Module: uart_word_loader

---
 rtl/uart_word_loader_pkg.sv | 26 ++
 rtl/uart_word_loader_rx.sv | 164 ++++++++++++++++
 rtl/uart_word_loader.sv | 131 +++++++++++++
 3 files changed

// File: rtl/uart_word_loader_pkg.sv
// Shared types and defaults for the UART instruction-word loader.
// Optional even-parity support is enabled with UART_LOADER_PARITY_EN.
package uart_word_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    localparam int DEF_CLKS_PER_BIT = 781;
    localparam int DEF_ADDR_W       = 14;

`ifdef UART_LOADER_PARITY_EN
    // The parity bit rides as a ninth sample in the DATA state.
    localparam logic [3:0] LAST_BIT_IDX = 4'd8;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`else
    localparam logic [3:0] LAST_BIT_IDX = 4'd7;
`endif

endpackage

// File: rtl/uart_word_loader_rx.sv
// uart_rx_byte: synchronizer, receive FSM and baud counter for one 8N1 byte
// (8E1 when UART_LOADER_PARITY_EN is defined).
module uart_rx_byte
    import uart_word_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       err_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic             rx_meta_q;
    logic             rx_sync_q;
    logic             rx_prev_q;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [7:0]       data_q, data_d;
    logic             frame_ok_s;
`ifdef UART_LOADER_PARITY_EN
    logic             par_q, par_d;
`endif

    assign byte_o = data_q;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // FSM state, baud counter, bit counter and data shift register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            bit_q   <= 4'd0;
            data_q  <= 8'd0;
`ifdef UART_LOADER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
`ifdef UART_LOADER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

`ifdef UART_LOADER_PARITY_EN
    assign frame_ok_s = rx_sync_q && (par_q == even_parity(data_q));
`else
    assign frame_ok_s = rx_sync_q;
`endif

    // Next-state logic; the byte/error strobes are asserted on the stop sample.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_ONE;
        bit_d        = bit_q;
        data_d       = data_q;
`ifdef UART_LOADER_PARITY_EN
        par_d        = par_q;
`endif
        byte_valid_o = 1'b0;
        err_o        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = CNT_ZERO;
                bit_d = 4'd0;
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_BIT) begin
                    cnt_d = CNT_ZERO;
                    if (!rx_sync_q) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (cnt_q == FULL_BIT) begin
                    cnt_d = CNT_ZERO;
                    bit_d = bit_q + 4'd1;
`ifdef UART_LOADER_PARITY_EN
                    if (bit_q == 4'd8) begin
                        par_d = rx_sync_q;
                    end else begin
                        data_d = {rx_sync_q, data_q[7:1]};
                    end
`else
                    data_d = {rx_sync_q, data_q[7:1]};
`endif
                    if (bit_q == LAST_BIT_IDX) begin
                        state_d = ST_STOP;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_STOP: begin
                if (cnt_q == FULL_BIT) begin
                    cnt_d   = CNT_ZERO;
                    state_d = ST_IDLE;
                    if (frame_ok_s) begin
                        byte_valid_o = 1'b1;
                    end else begin
                        err_o = 1'b1;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase

        // Leaving program mode aborts any frame in flight.
        if (!en_i) begin
            state_d      = ST_IDLE;
            cnt_d        = CNT_ZERO;
            bit_d        = 4'd0;
            byte_valid_o = 1'b0;
            err_o        = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

endmodule

// File: rtl/uart_word_loader.sv
// Assembles received UART bytes into big-endian 32-bit words and writes them
// to instruction memory. Optional parity: define UART_LOADER_PARITY_EN.
module uart_word_loader
    import uart_word_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int ADDR_W       = DEF_ADDR_W
) (
    input  logic              fpga_clk,
    input  logic              fpga_rst,
    input  logic              start_pg,
    input  logic              rx,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [ADDR_W:0]   word_cnt,
    output logic              frame_err
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   CNT_SAT  = {1'b1, {ADDR_W{1'b0}}};

    logic              rx_valid_s;
    logic [7:0]        rx_byte_s;
    logic              rx_err_s;
    logic              start_rise_s;

    logic              start_prev_q;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       shift_q, shift_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic              frame_err_q, frame_err_d;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk_i        (fpga_clk),
        .rst_i        (fpga_rst),
        .en_i         (start_pg),
        .rx_i         (rx),
        .byte_valid_o (rx_valid_s),
        .byte_o       (rx_byte_s),
        .err_o        (rx_err_s)
    );

    assign start_rise_s = start_pg && !start_prev_q;

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign word_cnt  = word_cnt_q;
    assign frame_err = frame_err_q;

    // Output and bookkeeping registers.
    always_ff @(posedge fpga_clk) begin
        if (fpga_rst) begin
            start_prev_q <= 1'b0;
            byte_idx_q   <= 2'd0;
            shift_q      <= 24'd0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= {ADDR_W{1'b0}};
            wr_data_q    <= 32'd0;
            word_cnt_q   <= {(ADDR_W + 1){1'b0}};
            frame_err_q  <= 1'b0;
        end else begin
            start_prev_q <= start_pg;
            byte_idx_q   <= byte_idx_d;
            shift_q      <= shift_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            word_cnt_q   <= word_cnt_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Word assembly, address/count advance and program-mode session control.
    always_comb begin
        wr_en_d     = 1'b0;
        byte_idx_d  = byte_idx_q;
        shift_d     = shift_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        word_cnt_d  = word_cnt_q;
        frame_err_d = frame_err_q;

        // Address and count advance the cycle after each write strobe.
        if (wr_en_q) begin
            wr_addr_d = wr_addr_q + ADDR_ONE;
            if (word_cnt_q != CNT_SAT) begin
                word_cnt_d = word_cnt_q + CNT_ONE;
            end else begin
                word_cnt_d = word_cnt_q;
            end
        end else begin
            wr_addr_d = wr_addr_q;
        end

        if (!start_pg) begin
            byte_idx_d = 2'd0;
        end else if (start_rise_s) begin
            byte_idx_d  = 2'd0;
            wr_addr_d   = {ADDR_W{1'b0}};
            word_cnt_d  = {(ADDR_W + 1){1'b0}};
            frame_err_d = 1'b0;
        end else begin
            if (rx_err_s) begin
                frame_err_d = 1'b1;
            end else begin
                frame_err_d = frame_err_q;
            end
            if (rx_valid_s) begin
                shift_d    = {shift_q[15:0], rx_byte_s};
                byte_idx_d = byte_idx_q + 2'd1;
                if (byte_idx_q == 2'd3) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = {shift_q, rx_byte_s};
                end else begin
                    wr_en_d = 1'b0;
                end
            end else begin
                byte_idx_d = byte_idx_q;
            end
        end
    end

endmodule
